// File: rtl/tag_ram_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache tag store: geometry, state encoding,
// and the functions that pack and unpack stored tag words.
package tag_ram_ctrl_pkg;
  localparam int SetNum   = 64;
  localparam int IdxW     = 6;
  localparam int OffW     = 4;
  localparam int TagW     = 32 - IdxW - OffW;
  localparam int ValidBit = 31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_MISS   = 3'd2,
    ST_REFILL = 3'd3,
    ST_WRITE  = 3'd4,
    ST_INV    = 3'd5
  } state_e;

  function automatic logic [31:0] pack_tag(input logic [TagW-1:0] tag);
    return {1'b1, {(ValidBit-TagW){1'b0}}, tag};
  endfunction

  function automatic logic word_valid(input logic [31:0] word);
    return word[ValidBit];
  endfunction

  function automatic logic [TagW-1:0] word_tag(input logic [31:0] word);
    return word[TagW-1:0];
  endfunction
endpackage

// File: rtl/tag_ram_ctrl_cmp.sv
// Tag compare: a stored word hits when its valid bit is set and its tag field matches.
module tag_ram_ctrl_cmp
  import tag_ram_ctrl_pkg::*;
(
  input  logic [31:0]     rdata,
  input  logic [TagW-1:0] tag,
  output logic            hit
);
  logic unused_pad;

  assign hit        = word_valid(rdata) && (word_tag(rdata) == tag);
  assign unused_pad = ^rdata[ValidBit-1:TagW];
endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag-RAM sequencer: lookup, miss refill handshake, tag write-back, invalidate-all sweep.
// Optional TAGCTRL_PERF_EN adds hit/miss performance counters.
module tag_ram_ctrl
  import tag_ram_ctrl_pkg::*;
#(
  parameter int SET_NUM = SetNum,
  parameter int IDX_W   = IdxW,
  parameter int OFF_W   = OffW,
  parameter int TAG_W   = TagW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [31:0]      req_addr,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             refill_valid,
  output logic [31:0]      refill_addr,
  input  logic             refill_ready,
  input  logic             refill_done,
  input  logic             inv_all,
  output logic             inv_busy,
  output logic [3:0]       tag_we,
  output logic [IDX_W-1:0] tag_waddr,
  output logic [31:0]      tag_wdata,
  output logic [IDX_W-1:0] tag_raddr,
  input  logic [31:0]      tag_rdata
`ifdef TAGCTRL_PERF_EN
  ,
  output logic [31:0]      perf_hit_cnt,
  output logic [31:0]      perf_miss_cnt
`endif
);
  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               hit;
  logic               sweep_start;
  logic               unused_off;

  assign unused_off = ^req_addr[OFF_W-1:0];
  assign tag_raddr  = (state_q == ST_IDLE) ? req_addr[OFF_W +: IDX_W] : idx_q;
  assign refill_addr = {tag_q, idx_q, {OFF_W{1'b0}}};
  assign req_ready  = (state_q == ST_IDLE) && !inv_all;
  assign sweep_start = (state_q == ST_IDLE) && inv_all;

  tag_ram_ctrl_cmp u_cmp (
    .rdata (tag_rdata),
    .tag   (tag_q),
    .hit   (hit)
  );

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    resp_valid   = 1'b0;
    resp_hit     = 1'b0;
    refill_valid = 1'b0;
    inv_busy     = 1'b0;
    tag_we       = 4'h0;
    tag_waddr    = '0;
    tag_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (inv_all) begin
          state_d = ST_INV;
          cnt_d   = '0;
        end else if (req_valid) begin
          tag_d   = req_addr[31 -: TAG_W];
          idx_d   = req_addr[OFF_W +: IDX_W];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        refill_valid = 1'b1;
        if (refill_ready) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (refill_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        tag_we     = 4'hF;
        tag_waddr  = idx_q;
        tag_wdata  = pack_tag(tag_q);
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_INV: begin
        inv_busy  = 1'b1;
        tag_we    = 4'hF;
        tag_waddr = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SET_NUM - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset must silence handshakes and RAM writes in the cycle it is asserted.
    if (rst) begin
      resp_valid   = 1'b0;
      resp_hit     = 1'b0;
      refill_valid = 1'b0;
      inv_busy     = 1'b0;
      tag_we       = 4'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TAGCTRL_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (sweep_start) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (resp_valid) begin
      if (resp_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
      else          miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
`else
  logic unused_sweep;
  assign unused_sweep = sweep_start;
`endif
endmodule

// File: doc/tag_ram_ctrl.md
Name: tag_ram_ctrl

Overview:
- Sequencer for the direct-mapped cache tag store: a simple dual-port 64-entry × 32-bit RAM with one write port and one registered read port.
- Serves CPU lookups and reports hit or miss.
- On a miss, issues a line-refill request and writes the new tag once the refill completes.
- Performs the invalidate-all sweep used by the cache-maintenance instruction.
- Sits between the CPU-side cache front end and the AXI refill engine; owns all tag-RAM port signals.

Parameters:
- SET_NUM, 64, number of sets; must match the tag RAM depth.
- IDX_W, 6, index width, log2(SET_NUM).
- OFF_W, 4, line-offset width (16-byte lines).
- TAG_W, 22, tag width, 32-IDX_W-OFF_W.

Ports:
- clk  in  1  single clock; also drives the tag RAM on both ports.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU lookup request.
- req_addr  in  32  physical address; sampled when req_valid && req_ready.
- req_ready  out  1  high only in IDLE with inv_all low.
- resp_valid  out  1  one-cycle pulse: lookup complete.
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = was a miss (now refilled).
- refill_valid  out  1  refill request to the refill engine.
- refill_addr  out  32  line address, {tag, index, OFF_W'b0}.
- refill_ready  in  1  refill engine accepts the request.
- refill_done  in  1  one-cycle pulse: line data written.
- inv_all  in  1  request to invalidate all sets (level; sampled in IDLE).
- inv_busy  out  1  high while the sweep is in progress.
- tag_we  out  4  byte write enables for the tag RAM; 4'hF or 0.
- tag_waddr  out  IDX_W  write index.
- tag_wdata  out  32  stored word, {valid, (31-TAG_W)'b0, tag}.
- tag_raddr  out  IDX_W  read index; data returns the next cycle.
- tag_rdata  in  32  registered read data; 0 for never-written entries.

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready = 1; sweep counter 0; request registers 0.
- Stored-word valid is bit 31. A hit requires rdata[31] == 1 and rdata[TAG_W-1:0] == the latched tag.
- tag_raddr is driven combinationally from req_addr[OFF_W+IDX_W-1:OFF_W] while in IDLE, and from the latched index otherwise.
- FSM states:
  - IDLE:
    - If inv_all: go to INV with counter = 0 and inv_busy = 1 (invalidate has priority over req_valid).
    - Else if req_valid: latch tag and index; go to LOOKUP.
  - LOOKUP: tag_rdata is valid this cycle.
    - Hit: resp_valid = 1, resp_hit = 1; go to IDLE. Total latency is 2 cycles from acceptance.
    - Miss: go to MISS.
  - MISS: refill_valid = 1 with refill_addr stable until refill_ready is seen high. Then go to REFILL.
    - If refill_ready is high on the first MISS cycle, the handshake completes in that same cycle.
  - REFILL: wait for refill_done; then go to WRITE.
  - WRITE: tag_we = 4'hF, tag_waddr = index, tag_wdata = {1'b1, 0, tag}; resp_valid = 1, resp_hit = 0; go to IDLE.
  - INV: each cycle write tag_wdata = 0 to tag_waddr = counter, then increment the counter.
    - At counter == SET_NUM-1, perform the final write, clear inv_busy, and go to IDLE. The sweep takes exactly SET_NUM cycles.
- Read-after-write: after WRITE, the next accepted request reads in the following cycle, so it observes the new tag. No bypass is needed.
- refill_done arriving outside REFILL is ignored.
- inv_all asserted mid-lookup or mid-refill is held off until IDLE; the in-flight refill always completes its WRITE.
- rst in any state returns to IDLE next cycle, drops refill_valid and inv_busy immediately, and causes no RAM write in that cycle.
- No resp_valid is ever produced from INV.

Optional Feature:
- Macro TAGCTRL_PERF_EN.
- Defined: adds outputs perf_hit_cnt[31:0] and perf_miss_cnt[31:0].
  - Incremented on resp_valid with resp_hit 1 or 0 respectively.
  - Wrap at 2^32; cleared by rst and by the start of an invalidate sweep.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared cache package holds: SetNum, index/offset/tag widths, the valid-bit position, state encodings (IDLE, LOOKUP, MISS, REFILL, WRITE, INV), and the tag-word pack/unpack functions.
- One natural sub-module, tag_ram_ctrl_cmp: combinational tag compare plus valid check, producing hit.

Test Plan:
- Cold lookup of 0x0000_1230: acceptance, then miss → refill_valid with refill_addr 0x0000_1230; refill_ready on the next cycle; refill_done 3 cycles later → WRITE at index 0x23 with wdata 0x8000_0000 | 0x4; resp_valid with resp_hit = 0.
- Repeat lookup of 0x0000_1234 → resp_valid with resp_hit = 1 exactly 2 cycles after acceptance; no refill_valid.
- Lookup 0x0040_1230 (same index, different tag) → miss and refill, then tag overwritten; a subsequent lookup of 0x0000_1230 → miss.
- inv_all and req_valid asserted together in IDLE → 64 consecutive writes of 0 to indices 0..63; inv_busy high for 64 cycles; then the request is accepted and misses.
- rst pulsed during REFILL → next cycle IDLE with refill_valid = 0; a later refill_done has no effect; a later lookup misses normally.
- With TAGCTRL_PERF_EN: 3 hits and 2 misses → perf_hit_cnt = 3, perf_miss_cnt = 2; inv_all clears both to 0.
